// File: rtl/nasti_simple_master_pkg.sv
// Shared NASTI encodings plus a helper that derives the AxSIZE field
// from the data-bus width.
package nasti_simple_master_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // AxSIZE encodes bytes-per-beat as a power of two.
  function automatic logic [2:0] beat_size(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/nasti_simple_master_if.sv
// Five-channel NASTI bundle. The master modport drives AW/W/AR and the
// B/R ready signals; the slave modport is its mirror image.
interface nasti_channel #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 128,
  parameter int USER_WIDTH = 1
);

  logic [ID_WIDTH-1:0]     aw_id;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;
  logic                    aw_lock;
  logic [3:0]              aw_cache;
  logic [2:0]              aw_prot;
  logic [3:0]              aw_qos;
  logic [3:0]              aw_region;
  logic [USER_WIDTH-1:0]   aw_user;
  logic                    aw_valid;
  logic                    aw_ready;

  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;
  logic [USER_WIDTH-1:0]   w_user;
  logic                    w_valid;
  logic                    w_ready;

  logic [ID_WIDTH-1:0]     b_id;
  logic [1:0]              b_resp;
  logic [USER_WIDTH-1:0]   b_user;
  logic                    b_valid;
  logic                    b_ready;

  logic [ID_WIDTH-1:0]     ar_id;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;
  logic                    ar_lock;
  logic [3:0]              ar_cache;
  logic [2:0]              ar_prot;
  logic [3:0]              ar_qos;
  logic [3:0]              ar_region;
  logic [USER_WIDTH-1:0]   ar_user;
  logic                    ar_valid;
  logic                    ar_ready;

  logic [ID_WIDTH-1:0]     r_id;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_last;
  logic [USER_WIDTH-1:0]   r_user;
  logic                    r_valid;
  logic                    r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );

endinterface

// File: rtl/nasti_simple_master.sv
// Single-outstanding bridge from a simple valid/ready request port to a
// NASTI master: one beat per transaction, one response per request.
module nasti_simple_master
  import nasti_simple_master_pkg::*;
#(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 128,
  parameter int USER_WIDTH = 1,
  parameter int MASTER_ID  = 0
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  nasti_channel.master            nasti
);

  localparam int                    SIZE_BITS = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
    ~((ADDR_WIDTH'(1) << SIZE_BITS) - ADDR_WIDTH'(1));
  localparam logic [ID_WIDTH-1:0]   ID = ID_WIDTH'(MASTER_ID);

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA, RESP} state_e;

  state_e                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [DATA_WIDTH/8-1:0]   wstrb_q;
  logic                      aw_done_q, w_done_q;
  logic                      first_q;
  logic [DATA_WIDTH-1:0]     rdata_q;
  logic                      err_q;

  // Fires are built from registered state and the slave's ready only, so
  // no valid ever loops back through its own ready.
  logic aw_fire, w_fire;
  assign aw_fire = !aw_done_q && nasti.aw_ready;
  assign w_fire  = !w_done_q  && nasti.w_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, which keeps
  // synthesis from inferring latches on paths that skip an assignment.
  always_comb begin
    state_d        = state_q;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    nasti.aw_valid = 1'b0;
    nasti.w_valid  = 1'b0;
    nasti.b_ready  = 1'b0;
    nasti.ar_valid = 1'b0;
    nasti.r_ready  = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_write ? WRITE : RADDR;
      end
      WRITE: begin
        nasti.aw_valid = !aw_done_q;
        nasti.w_valid  = !w_done_q;
        if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) state_d = WRESP;
      end
      WRESP: begin
        nasti.b_ready = 1'b1;
        if (nasti.b_valid) state_d = RESP;
      end
      RADDR: begin
        nasti.ar_valid = 1'b1;
        if (nasti.ar_ready) state_d = RDATA;
      end
      RDATA: begin
        nasti.r_ready = 1'b1;
        if (nasti.r_valid && nasti.r_last) state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      first_q   <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (req_valid) begin
          addr_q    <= req_addr & ADDR_MASK;
          wdata_q   <= req_wdata;
          wstrb_q   <= req_wstrb;
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
          first_q   <= 1'b1;
          rdata_q   <= '0;
          err_q     <= 1'b0;
        end
        WRITE: begin
          if (aw_fire) aw_done_q <= 1'b1;
          if (w_fire)  w_done_q  <= 1'b1;
        end
        WRESP: if (nasti.b_valid)
          err_q <= (nasti.b_resp != RESP_OKAY) || (nasti.b_id != ID);
        RDATA: if (nasti.r_valid) begin
          if (first_q) begin
            rdata_q <= nasti.r_data;
            first_q <= 1'b0;
          end
          // A premature r_last=0 beat is sticky-flagged; draining continues.
          err_q <= err_q || (nasti.r_resp != RESP_OKAY) ||
                   (nasti.r_id != ID) || !nasti.r_last;
        end
        default: ;
      endcase
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  assign nasti.aw_id     = ID;
  assign nasti.aw_addr   = addr_q;
  assign nasti.aw_len    = 8'd0;
  assign nasti.aw_size   = beat_size(DATA_WIDTH);
  assign nasti.aw_burst  = BURST_INCR;
  assign nasti.aw_lock   = 1'b0;
  assign nasti.aw_cache  = 4'd0;
  assign nasti.aw_prot   = 3'd0;
  assign nasti.aw_qos    = 4'd0;
  assign nasti.aw_region = 4'd0;
  assign nasti.aw_user   = '0;

  assign nasti.w_data    = wdata_q;
  assign nasti.w_strb    = wstrb_q;
  assign nasti.w_last    = 1'b1;
  assign nasti.w_user    = '0;

  assign nasti.ar_id     = ID;
  assign nasti.ar_addr   = addr_q;
  assign nasti.ar_len    = 8'd0;
  assign nasti.ar_size   = beat_size(DATA_WIDTH);
  assign nasti.ar_burst  = BURST_INCR;
  assign nasti.ar_lock   = 1'b0;
  assign nasti.ar_cache  = 4'd0;
  assign nasti.ar_prot   = 3'd0;
  assign nasti.ar_qos    = 4'd0;
  assign nasti.ar_region = 4'd0;
  assign nasti.ar_user   = '0;

endmodule

// File: doc/nasti_simple_master.md
NASTI_SIMPLE_MASTER -- requirements
Module: nasti_simple_master

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 1, the NASTI ID width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, the NASTI address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 128, the NASTI and request data width, a power of two from 8 to 256.
REQ-004 SHALL have parameter USER_WIDTH, default 1, the NASTI user width.
REQ-005 SHALL have parameter MASTER_ID, default 0, the constant ID driven on aw_id and ar_id.
REQ-006 SHALL have port clk, input, 1 bit: the clock.
REQ-007 SHALL have port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port req_valid, input, 1 bit: a request is offered.
REQ-009 SHALL have port req_ready, output, 1 bit: the request is accepted.
REQ-010 SHALL have port req_write, input, 1 bit: 1 = write, 0 = read.
REQ-011 SHALL have port req_addr, input, ADDR_WIDTH: byte address.
REQ-012 SHALL have port req_wdata, input, DATA_WIDTH: write data.
REQ-013 SHALL have port req_wstrb, input, DATA_WIDTH/8: write byte strobes.
REQ-014 SHALL have port resp_valid, output, 1 bit: a response is offered.
REQ-015 SHALL have port resp_ready, input, 1 bit: the response is accepted.
REQ-016 SHALL have port resp_rdata, output, DATA_WIDTH: read data; zero for writes.
REQ-017 SHALL have port resp_err, output, 1 bit: the transaction failed.
REQ-018 SHALL have port nasti, interface nasti_channel.master, all five channels, driving the downstream NASTI slave (behavioural RAM or BRAM controller).

Function
REQ-019 SHALL allow only one outstanding transaction, using the FSM states IDLE, WRITE, WRESP, RADDR, RDATA and RESP.
REQ-020 SHALL drive req_ready=1 only in IDLE; a request is accepted when req_valid and req_ready are both high at a posedge.
REQ-021 SHALL, on accepting a write, register the address, data and strobes, and go to WRITE, where aw_valid and w_valid both assert from the next cycle.
REQ-022 SHALL, in WRITE, drop aw_valid and w_valid independently after their handshakes, in the same cycle or in either order, and go to WRESP once both have completed.
REQ-023 SHALL, in WRESP, hold b_ready=1; on the b handshake, capture the error condition and go to RESP.
REQ-024 SHALL, on accepting a read, go to RADDR and assert ar_valid until the ar handshake, then go to RDATA.
REQ-025 SHALL, in RDATA, hold r_ready=1, capture r_data from the first beat, and go to RESP on the beat with r_last=1.
REQ-026 SHALL, in RDATA, if any beat arrives with r_last=0, set the error flag and keep consuming beats until r_last=1.
REQ-027 SHALL set the error flag when resp is not OKAY (2'b00) or when b_id or r_id is not MASTER_ID.
REQ-028 SHALL, in RESP, hold resp_valid=1 with stable resp_rdata and resp_err, and return to IDLE on resp_ready; req_ready stays 0 through the return cycle.
REQ-029 SHALL drive address-channel fields as len=0, size=log2(DATA_WIDTH/8), burst=INCR (2'b01), id=MASTER_ID, and lock, cache, prot, qos, region and user all 0.
REQ-030 SHALL drive the address with the low log2(DATA_WIDTH/8) bits forced to 0, and drive w_last=1 and w_user=0.
REQ-031 SHALL never make a NASTI valid depend combinationally on the matching ready, and shall hold each valid and its payload stable until its handshake.
REQ-032 SHALL tolerate ready signals that change on the negedge, sampling every handshake only at the posedge.
REQ-033 SHALL take at least 3 cycles from request acceptance to resp_valid when the slave responds with zero wait.

Reset
REQ-034 SHALL, while rstn=0, asynchronously force the FSM to IDLE and drive every valid, b_ready, r_ready, resp_valid and resp_err to 0, and resp_rdata to 0.
REQ-035 SHALL abandon any in-flight transaction on reset with no response; re-syncing the slave is the system's responsibility.

Structure
REQ-036 SHALL take the NASTI burst and response encodings (INCR, OKAY, SLVERR, DECERR) from the shared NASTI package.
REQ-037 SHALL be a single module with no sub-modules; the FSM state enum is local to it.

Verification
REQ-038 Write, zero-wait slave: addr 0x0010, wdata 0xA5..A5, wstrb all 1s -> aw_addr 0x0010, w_last=1, single b, then resp_valid with resp_err=0.
REQ-039 Read back the same address -> ar_len=0, resp_rdata 0xA5..A5, resp_err=0.
REQ-040 Slave that sets w_ready 3 cycles before aw_ready -> both channels complete, exactly one w beat, correct response.
REQ-041 Slave that returns b_resp=SLVERR -> resp_err=1; a later OKAY read returns resp_err=0.
REQ-042 Hold resp_ready=0 for 5 cycles -> resp_valid and data stay stable, req_ready=0, no new NASTI activity.
REQ-043 Deassert rstn while ar_valid=1 -> ar_valid=0 and the FSM in IDLE immediately; the next request proceeds normally, using a resettable slave model.
